// File: rtl/umi_tx_fifo_pkg.sv
// Shared sizing helpers for the UMI TX FIFO: packed packet width and field offsets.
// A packet is packed as {cmd, dstaddr, srcaddr, data}, with cmd in the MSBs.
package umi_tx_fifo_pkg;

  function automatic int umi_pw(input int cw, input int aw, input int dw);
    return cw + 2*aw + dw;
  endfunction

  // LSB offset of each field inside the packed word
  function automatic int umi_off_srcaddr(input int dw);
    return dw;
  endfunction

  function automatic int umi_off_dstaddr(input int aw, input int dw);
    return dw + aw;
  endfunction

  function automatic int umi_off_cmd(input int aw, input int dw);
    return dw + 2*aw;
  endfunction

endpackage

// File: rtl/umi_tx_fifo_mem.sv
// Packet storage for the UMI TX FIFO: synchronous write, asynchronous read so the
// head entry is visible in the same cycle its pointer selects it.
module umi_tx_fifo_mem #(
  parameter int PW    = 416,
  parameter int DEPTH = 4,
  parameter int AD    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AD-1:0] waddr,
  input  logic [PW-1:0] wdata,
  input  logic [AD-1:0] raddr,
  output logic [PW-1:0] rdata
);

  logic [PW-1:0] mem_reg [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_reg[waddr] <= wdata;
  end

  assign rdata = mem_reg[raddr];

endmodule

// File: rtl/umi_tx_fifo.sv
// First-word-fall-through packet FIFO feeding the UMI-to-queue TX block.
// Pointers carry an extra wrap bit so full and empty are distinguishable.
module umi_tx_fifo
  import umi_tx_fifo_pkg::*;
#(
  parameter int DW          = 256,
  parameter int AW          = 64,
  parameter int CW          = 32,
  parameter int DEPTH       = 4,
  parameter int AFULL_LEVEL = 3
) (
  input  logic                   clk,
  input  logic                   nreset,
  input  logic                   umi_in_valid,
  input  logic [CW-1:0]          umi_in_cmd,
  input  logic [AW-1:0]          umi_in_dstaddr,
  input  logic [AW-1:0]          umi_in_srcaddr,
  input  logic [DW-1:0]          umi_in_data,
  output logic                   umi_in_ready,
  output logic                   umi_out_valid,
  output logic [CW-1:0]          umi_out_cmd,
  output logic [AW-1:0]          umi_out_dstaddr,
  output logic [AW-1:0]          umi_out_srcaddr,
  output logic [DW-1:0]          umi_out_data,
  input  logic                   umi_out_ready,
  output logic [$clog2(DEPTH):0] count,
  output logic                   afull,
  output logic                   empty
);

  localparam int PW      = umi_pw(CW, AW, DW);
  localparam int AD      = $clog2(DEPTH);
  localparam int PTRW    = AD + 1;
  localparam int OFF_SRC = umi_off_srcaddr(DW);
  localparam int OFF_DST = umi_off_dstaddr(AW, DW);
  localparam int OFF_CMD = umi_off_cmd(AW, DW);
  localparam logic [PTRW-1:0] AFULL_CNT = PTRW'(AFULL_LEVEL);

  logic [PTRW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic            full;
  logic            push, pop;
  logic [PW-1:0]   wdata, rdata;

  assign full  = (wr_ptr_reg[AD] != rd_ptr_reg[AD]) &&
                 (wr_ptr_reg[AD-1:0] == rd_ptr_reg[AD-1:0]);
  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign count = wr_ptr_reg - rd_ptr_reg;
  assign afull = (count >= AFULL_CNT);

  // ready depends only on occupancy, so there is no comb path from umi_out_ready
  assign umi_in_ready  = !full;
  assign umi_out_valid = !empty;
  assign push          = umi_in_valid && umi_in_ready;
  assign pop           = umi_out_valid && umi_out_ready;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  assign wdata = {umi_in_cmd, umi_in_dstaddr, umi_in_srcaddr, umi_in_data};

  umi_tx_fifo_mem #(
    .PW    (PW),
    .DEPTH (DEPTH),
    .AD    (AD)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr_reg[AD-1:0]),
    .wdata (wdata),
    .raddr (rd_ptr_reg[AD-1:0]),
    .rdata (rdata)
  );

  assign umi_out_cmd     = rdata[OFF_CMD +: CW];
  assign umi_out_dstaddr = rdata[OFF_DST +: AW];
  assign umi_out_srcaddr = rdata[OFF_SRC +: AW];
  assign umi_out_data    = rdata[DW-1:0];

endmodule

// File: tb/tb_umi_tx_fifo.sv
// Directed table-driven bench for umi_tx_fifo plus hand-written multi-cycle sequences
// (latency, async reset, randomly stalled stream across pointer wrap).
module tb_umi_tx_fifo;

  localparam int DW = 256;
  localparam int AW = 64;
  localparam int CW = 32;
  localparam int PW = CW + 2*AW + DW;

  logic          clk = 1'b0;
  logic          nreset;
  logic          umi_in_valid;
  logic [CW-1:0] umi_in_cmd;
  logic [AW-1:0] umi_in_dstaddr;
  logic [AW-1:0] umi_in_srcaddr;
  logic [DW-1:0] umi_in_data;
  logic          umi_in_ready;
  logic          umi_out_valid;
  logic [CW-1:0] umi_out_cmd;
  logic [AW-1:0] umi_out_dstaddr;
  logic [AW-1:0] umi_out_srcaddr;
  logic [DW-1:0] umi_out_data;
  logic          umi_out_ready;
  logic [2:0]    count;
  logic          afull;
  logic          empty;

  int nvec  = 0;
  int nfail = 0;

  umi_tx_fifo #(
    .DW(DW), .AW(AW), .CW(CW), .DEPTH(4), .AFULL_LEVEL(3)
  ) dut (
    .clk             (clk),
    .nreset          (nreset),
    .umi_in_valid    (umi_in_valid),
    .umi_in_cmd      (umi_in_cmd),
    .umi_in_dstaddr  (umi_in_dstaddr),
    .umi_in_srcaddr  (umi_in_srcaddr),
    .umi_in_data     (umi_in_data),
    .umi_in_ready    (umi_in_ready),
    .umi_out_valid   (umi_out_valid),
    .umi_out_cmd     (umi_out_cmd),
    .umi_out_dstaddr (umi_out_dstaddr),
    .umi_out_srcaddr (umi_out_srcaddr),
    .umi_out_data    (umi_out_data),
    .umi_out_ready   (umi_out_ready),
    .count           (count),
    .afull           (afull),
    .empty           (empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       iv;
    logic       ordy;
    logic [7:0] tag;
    logic [2:0] cnt;
    logic       ov;
    logic       ir;
    logic       af;
    logic       em;
    logic [7:0] head;
  } vec_t;

  vec_t tbl [17];

  function automatic vec_t mkv(logic iv, logic ordy, logic [7:0] tag, logic [2:0] cnt,
                               logic ov, logic ir, logic af, logic em, logic [7:0] head);
    vec_t v;
    v.iv = iv; v.ordy = ordy; v.tag = tag; v.cnt = cnt;
    v.ov = ov; v.ir = ir; v.af = af; v.em = em; v.head = head;
    return v;
  endfunction

  // Packed packet the bench expects for a given tag
  function automatic logic [PW-1:0] pkt(logic [7:0] tag);
    logic [CW-1:0] c;
    logic [AW-1:0] d, s;
    logic [DW-1:0] x;
    c = 32'h0000_0100 | {24'd0, tag};
    d = 64'h1000 + {56'd0, tag};
    s = 64'h2000 + {56'd0, tag};
    x = {32{tag}};
    return {c, d, s, x};
  endfunction

  task automatic drive_tag(logic [7:0] tag);
    logic [PW-1:0] p;
    p = pkt(tag);
    umi_in_cmd     = p[PW-1 -: CW];
    umi_in_dstaddr = p[DW+2*AW-1 -: AW];
    umi_in_srcaddr = p[DW+AW-1 -: AW];
    umi_in_data    = p[DW-1:0];
  endtask

  task automatic chk(string name, logic [PW-1:0] act, logic [PW-1:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [PW-1:0] out_pkt();
    return {umi_out_cmd, umi_out_dstaddr, umi_out_srcaddr, umi_out_data};
  endfunction

  initial begin
    logic [DW-1:0] prev_data;
    logic          prev_stall;
    logic          acc_push, acc_pop;
    logic [DW-1:0] pop_data;
    int            sent, recv;

    nreset = 1'b0;
    umi_in_valid = 1'b0;
    umi_out_ready = 1'b0;
    drive_tag(8'd0);

    // ready, afull, empty, count in table order: iv ordy tag | cnt ov ir af em head
    tbl[0]  = mkv(0, 0, 0, 0, 0, 1, 0, 1, 0);
    tbl[1]  = mkv(1, 0, 1, 1, 1, 1, 0, 0, 1);
    tbl[2]  = mkv(1, 0, 2, 2, 1, 1, 0, 0, 1);
    tbl[3]  = mkv(1, 0, 3, 3, 1, 1, 1, 0, 1);
    tbl[4]  = mkv(1, 0, 4, 4, 1, 0, 1, 0, 1);
    tbl[5]  = mkv(1, 0, 5, 4, 1, 0, 1, 0, 1);
    tbl[6]  = mkv(1, 0, 5, 4, 1, 0, 1, 0, 1);
    tbl[7]  = mkv(1, 0, 5, 4, 1, 0, 1, 0, 1);
    tbl[8]  = mkv(1, 1, 5, 3, 1, 1, 1, 0, 2);
    tbl[9]  = mkv(1, 1, 5, 3, 1, 1, 1, 0, 3);
    tbl[10] = mkv(0, 1, 0, 2, 1, 1, 0, 0, 4);
    tbl[11] = mkv(1, 1, 6, 2, 1, 1, 0, 0, 5);
    tbl[12] = mkv(1, 1, 7, 2, 1, 1, 0, 0, 6);
    tbl[13] = mkv(1, 1, 8, 2, 1, 1, 0, 0, 7);
    tbl[14] = mkv(0, 1, 0, 1, 1, 1, 0, 0, 8);
    tbl[15] = mkv(0, 1, 0, 0, 0, 1, 0, 1, 0);
    tbl[16] = mkv(0, 0, 0, 0, 0, 1, 0, 1, 0);

    #22;
    chk("reset_valid", PW'(umi_out_valid), PW'(1'b0));
    chk("reset_empty", PW'(empty), PW'(1'b1));
    chk("reset_count", PW'(count), PW'(0));
    chk("reset_ready", PW'(umi_in_ready), PW'(1'b1));
    chk("reset_afull", PW'(afull), PW'(1'b0));
    @(negedge clk);
    nreset = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 17; i++) begin
      umi_in_valid  = tbl[i].iv;
      umi_out_ready = tbl[i].ordy;
      drive_tag(tbl[i].tag);
      @(posedge clk); #1;
      $display("vec %0d: iv=%0d ordy=%0d tag=%0d -> count=%0d ov=%0d ir=%0d af=%0d em=%0d",
               i, tbl[i].iv, tbl[i].ordy, tbl[i].tag, count, umi_out_valid,
               umi_in_ready, afull, empty);
      chk($sformatf("v%0d_count", i), PW'(count), PW'(tbl[i].cnt));
      chk($sformatf("v%0d_ovalid", i), PW'(umi_out_valid), PW'(tbl[i].ov));
      chk($sformatf("v%0d_iready", i), PW'(umi_in_ready), PW'(tbl[i].ir));
      chk($sformatf("v%0d_afull", i), PW'(afull), PW'(tbl[i].af));
      chk($sformatf("v%0d_empty", i), PW'(empty), PW'(tbl[i].em));
      if (tbl[i].ov) chk($sformatf("v%0d_head", i), out_pkt(), pkt(tbl[i].head));
    end

    // Latency: pushed packet appears one cycle later, never same-cycle
    umi_in_valid   = 1'b1;
    umi_out_ready  = 1'b1;
    umi_in_cmd     = 32'h05;
    umi_in_dstaddr = 64'h1000;
    umi_in_srcaddr = 64'h2000;
    umi_in_data    = {32{8'hAA}};
    #1;
    chk("lat_no_bypass", PW'(umi_out_valid), PW'(1'b0));
    @(posedge clk); #1;
    umi_in_valid = 1'b0;
    $display("latency: ov=%0d cmd=%0h", umi_out_valid, umi_out_cmd);
    chk("lat_valid", PW'(umi_out_valid), PW'(1'b1));
    chk("lat_payload", out_pkt(), {32'h05, 64'h1000, 64'h2000, {32{8'hAA}}});
    @(posedge clk); #1;
    chk("lat_popped_empty", PW'(empty), PW'(1'b1));

    // Asynchronous reset with three packets buffered
    umi_out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      umi_in_valid = 1'b1;
      drive_tag(8'(20 + i));
      @(posedge clk); #1;
    end
    umi_in_valid = 1'b0;
    chk("arst_pre_count", PW'(count), PW'(3));
    nreset = 1'b0;
    #1;
    $display("async reset: count=%0d ov=%0d em=%0d ir=%0d af=%0d",
             count, umi_out_valid, empty, umi_in_ready, afull);
    chk("arst_count", PW'(count), PW'(0));
    chk("arst_valid", PW'(umi_out_valid), PW'(1'b0));
    chk("arst_empty", PW'(empty), PW'(1'b1));
    chk("arst_ready", PW'(umi_in_ready), PW'(1'b1));
    chk("arst_afull", PW'(afull), PW'(1'b0));
    @(negedge clk);
    nreset = 1'b1;
    @(posedge clk); #1;
    chk("arst_after_valid", PW'(umi_out_valid), PW'(1'b0));

    // Stream 20 indexed packets through random output stalls
    sent = 0;
    recv = 0;
    prev_stall = 1'b0;
    prev_data = '0;
    for (int cyc = 0; cyc < 400 && recv < 20; cyc++) begin
      umi_in_valid  = (sent < 20);
      drive_tag(8'(sent));
      umi_in_data   = DW'(sent);
      umi_out_ready = 1'($urandom_range(0, 1));
      if (prev_stall) begin
        chk("stall_valid", PW'(umi_out_valid), PW'(1'b1));
        chk("stall_payload", PW'(umi_out_data), PW'(prev_data));
      end
      @(negedge clk);
      acc_push   = umi_in_valid && umi_in_ready;
      acc_pop    = umi_out_valid && umi_out_ready;
      pop_data   = umi_out_data;
      prev_stall = umi_out_valid && !umi_out_ready;
      prev_data  = umi_out_data;
      @(posedge clk); #1;
      if (acc_push) sent++;
      if (acc_pop) begin
        $display("stream: popped index %0d (expected %0d)", pop_data, recv);
        chk("stream_order", PW'(pop_data), PW'(recv));
        recv++;
      end
    end
    umi_in_valid = 1'b0;
    umi_out_ready = 1'b0;
    chk("stream_done", PW'(recv), PW'(20));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/umi_tx_fifo.md
Name: umi_tx_fifo

Overview:
Buffered UMI packet stage placed directly upstream of the UMI-to-queue TX simulation block. It accepts UMI transactions (cmd/dstaddr/srcaddr/data with valid/ready) from DUT-side logic and stores them in a circular FIFO. It presents them first-word-fall-through on an output port whose signals map 1:1 onto the TX block's cmd/dstaddr/srcaddr/data/valid/ready. This decouples DUT issue rate from queue back-pressure and exposes fill level for bench monitoring.

Parameters:
DW, 256, UMI data width in bits
AW, 64, UMI address width in bits
CW, 32, UMI command width in bits
DEPTH, 4, number of packet entries; power of two, >=2
AFULL_LEVEL, 3, count at or above which afull asserts; 1..DEPTH

Ports:
clk  input  1  clock, all state on rising edge
nreset  input  1  asynchronous active-low reset
umi_in_valid  input  1  upstream packet valid
umi_in_cmd  input  CW  upstream command
umi_in_dstaddr  input  AW  upstream destination address
umi_in_srcaddr  input  AW  upstream source address
umi_in_data  input  DW  upstream data
umi_in_ready  output  1  FIFO can accept a packet
umi_out_valid  output  1  head packet valid (drives TX valid)
umi_out_cmd  output  CW  head command
umi_out_dstaddr  output  AW  head destination address
umi_out_srcaddr  output  AW  head source address
umi_out_data  output  DW  head data
umi_out_ready  input  1  TX stage accepts head packet
count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
afull  output  1  count >= AFULL_LEVEL
empty  output  1  count == 0

Behaviour:
- One clock (clk); reset asynchronous, active-low (nreset). Assertion immediately clears wr_ptr, rd_ptr, count; umi_out_valid=0, empty=1, afull=0, umi_in_ready=1 (after reset releases, ready is combinationally !full). Stored payload is not reset; umi_out_* payload is don't-care while valid=0.
- Pointers: $clog2(DEPTH)+1 bits, MSB is wrap bit. full = (wr[MSB]!=rd[MSB]) && (low bits equal); empty = pointers equal. count = wr_ptr - rd_ptr (modular, width of pointer).
- Push: umi_in_valid && umi_in_ready at edge -> write {cmd,dstaddr,srcaddr,data} at wr_ptr, wr_ptr++.
- Pop: umi_out_valid && umi_out_ready at edge -> rd_ptr++.
- umi_in_ready = !full; depends only on state, never on umi_out_ready (no comb path in->out ready).
- umi_out_valid = !empty; payload = entry at rd_ptr (FWFT). Latency: packet pushed in cycle N is visible on umi_out in cycle N+1; no same-cycle bypass when empty.
- Payload and valid held stable while umi_out_valid && !umi_out_ready.
- Simultaneous push+pop: allowed whenever neither full nor empty blocks it; count unchanged. When full, push is blocked even if a pop occurs that cycle; ready rises the following cycle.
- Pointers wrap modulo 2*DEPTH; ordering strictly preserved across wrap.
- umi_in_valid with ready=0: no state change; upstream must hold the packet (UMI rule).
- Reset mid-operation: all buffered packets discarded; no partial packet emitted.

Decomposition:
- Package umi_tx_fifo_pkg: function/constant for packed width PW = CW+2*AW+DW. Field offsets for pack/unpack in the order cmd (MSBs), dstaddr, srcaddr, data (LSBs).
- Sub-module umi_tx_fifo_mem: DEPTH x PW register array, sync write port, async read port; no reset.
- Top holds pointers, flags, and pack/unpack.

Test Plan:
- Reset then idle -> umi_out_valid=0, empty=1, count=0, umi_in_ready=1. Assert nreset low mid-run with count=3 -> same values immediately, before the next clk edge.
- Push cmd=0x05, dstaddr=0x1000, srcaddr=0x2000, data=0xAA.., umi_out_ready=1 -> umi_out_valid rises exactly one cycle later with identical fields. Popped next edge -> empty=1.
- DEPTH=4, umi_out_ready=0, push 4 packets -> count=4, umi_in_ready=0, afull=1 from count 3. 5th valid held 3 cycles -> no write, count stays 4.
- Full FIFO, assert umi_out_ready=1 and umi_in_valid=1 in the same cycle -> pop only, count=3. Next cycle ready=1 and push accepted, count stays 3.
- Stream 20 packets with data=index, random umi_out_ready stalls (~50%) -> received indices 0..19 in order across pointer wrap. Payload stable on every stalled cycle.
- Steady push+pop every cycle from count=2 -> count constant 2, throughput 1 packet/cycle.
